// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one 4x4 lookup multiplier across N_REQ requesters
// through a 2-stage valid/ready pipeline. Optional macro: MULT_SHARE_ARBITER_STATS_EN.
module mult_share_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     io_req_valid,
    output logic [N_REQ-1:0]     io_req_ready,
    input  logic [4*N_REQ-1:0]   io_req_lhs,
    input  logic [4*N_REQ-1:0]   io_req_rhs,
    output logic                 io_resp_valid,
    input  logic                 io_resp_ready,
    output logic [ID_W-1:0]      io_resp_id,
    output logic [7:0]           io_resp_data,
    output logic                 io_busy
`ifdef MULT_SHARE_ARBITER_STATS_EN
    ,
    output logic [16*N_REQ-1:0]  io_grant_cnt
`endif
);

    // Shared 4x4 product table; every entry fits in 8 bits (max 0xE1).
    function automatic logic [7:0] fast_mult(input logic [3:0] a, input logic [3:0] b);
        return {4'b0000, a} * {4'b0000, b};
    endfunction

    logic [ID_W-1:0] r_last;
    logic            r_s1_valid;
    logic [3:0]      r_s1_lhs;
    logic [3:0]      r_s1_rhs;
    logic [ID_W-1:0] r_s1_id;
    logic            r_s2_valid;
    logic [7:0]      r_s2_data;
    logic [ID_W-1:0] r_s2_id;

    logic            w_grant_found;
    logic [ID_W-1:0] w_grant_id;
    logic            w_s2_adv;
    logic            w_s1_adv;
    logic            w_accept;
    logic [3:0]      w_win_lhs;
    logic [3:0]      w_win_rhs;

    // Round-robin search starting just after the last winner, wrapping.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(r_last) + 1 + k) % N_REQ;
            if (!w_grant_found && io_req_valid[idx]) begin
                w_grant_found = 1'b1;
                w_grant_id    = ID_W'(idx);
            end else begin
                w_grant_found = w_grant_found;
            end
        end
    end

    // Handshake decode; accept is held off while reset is asserted so ready stays low.
    always_comb begin
        w_s2_adv     = !r_s2_valid || io_resp_ready;
        w_s1_adv     = !r_s1_valid || w_s2_adv;
        w_accept     = w_grant_found && w_s1_adv && reset;
        w_win_lhs    = io_req_lhs[4*int'(w_grant_id) +: 4];
        w_win_rhs    = io_req_rhs[4*int'(w_grant_id) +: 4];
        io_req_ready = '0;
        if (w_accept) begin
            io_req_ready[w_grant_id] = 1'b1;
        end else begin
            io_req_ready = '0;
        end
    end

    // Pipeline stages and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last     <= ID_W'(N_REQ - 1);
            r_s1_valid <= 1'b0;
            r_s1_lhs   <= 4'h0;
            r_s1_rhs   <= 4'h0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= 8'h00;
            r_s2_id    <= '0;
        end else begin
            if (w_accept) begin
                r_s1_lhs   <= w_win_lhs;
                r_s1_rhs   <= w_win_rhs;
                r_s1_id    <= w_grant_id;
                r_s1_valid <= 1'b1;
                r_last     <= w_grant_id;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (r_s1_valid && w_s2_adv) begin
                r_s2_data  <= fast_mult(r_s1_lhs, r_s1_rhs);
                r_s2_id    <= r_s1_id;
                r_s2_valid <= 1'b1;
            end else if (io_resp_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign io_resp_valid = r_s2_valid;
    assign io_resp_data  = r_s2_data;
    assign io_resp_id    = r_s2_id;
    assign io_busy       = r_s1_valid || r_s2_valid;

`ifdef MULT_SHARE_ARBITER_STATS_EN
    for (genvar g = 0; g < N_REQ; g++) begin : g_stats
        logic [15:0] r_cnt;
        // Saturating per-requester accept counter.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_cnt <= 16'h0000;
            end else if (w_accept && (w_grant_id == ID_W'(g)) && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'h0001;
            end
        end
        assign io_grant_cnt[16*g +: 16] = r_cnt;
    end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Table-driven bench for mult_share_arbiter with a cycle-stepped reference model
// and a response scoreboard queue.
module tb_mult_share_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  io_req_valid;
    logic [3:0]  io_req_ready;
    logic [15:0] io_req_lhs;
    logic [15:0] io_req_rhs;
    logic        io_resp_valid;
    logic        io_resp_ready;
    logic [1:0]  io_resp_id;
    logic [7:0]  io_resp_data;
    logic        io_busy;

    mult_share_arbiter #(.N_REQ(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_req_valid (io_req_valid),
        .io_req_ready (io_req_ready),
        .io_req_lhs   (io_req_lhs),
        .io_req_rhs   (io_req_rhs),
        .io_resp_valid(io_resp_valid),
        .io_resp_ready(io_resp_ready),
        .io_resp_id   (io_resp_id),
        .io_resp_data (io_resp_data),
        .io_busy      (io_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] lhs;
        logic [15:0] rhs;
        logic        rr;
        logic [3:0]  exp_rdy;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } resp_t;

    vec_t  tbl[$];
    resp_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;

    // reference model state
    logic [1:0] m_last = 2'd3;
    logic       m_s1v  = 1'b0;
    logic       m_s2v  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic [3:0] v, input logic [15:0] l, input logic [15:0] r,
                                input logic rr, input logic [3:0] e);
        vec_t x;
        x.valid = v; x.lhs = l; x.rhs = r; x.rr = rr; x.exp_rdy = e;
        tbl.push_back(x);
    endfunction

    // One cycle: drive at negedge, check, update model, advance to next negedge.
    task automatic step(input logic [3:0] v, input logic [15:0] l, input logic [15:0] r,
                        input logic rr, input logic [3:0] e);
        logic       found;
        logic [1:0] gid;
        logic       s2a, s1a, acc;
        logic [3:0] mrdy;
        logic [3:0] a, b;
        resp_t      ent;
        io_req_valid  = v;
        io_req_lhs    = l;
        io_req_rhs    = r;
        io_resp_ready = rr;
        #1;
        found = 1'b0;
        gid   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (int'(m_last) + 1 + k) % 4;
            if (!found && v[idx]) begin
                found = 1'b1;
                gid   = 2'(idx);
            end
        end
        s2a  = !m_s2v || rr;
        s1a  = !m_s1v || s2a;
        acc  = found && s1a;
        mrdy = acc ? (4'b0001 << gid) : 4'b0000;
        check("req_ready_tbl", 32'(io_req_ready), 32'(e));
        check("req_ready_model", 32'(io_req_ready), 32'(mrdy));
        check("resp_valid", 32'(io_resp_valid), 32'(m_s2v));
        check("busy", 32'(io_busy), 32'(m_s1v || m_s2v));
        if (m_s2v) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 32'd0, 32'd1);
            end else begin
                check("resp_id", 32'(io_resp_id), 32'(sb[0].id));
                check("resp_data", 32'(io_resp_data), 32'(sb[0].data));
                if (rr) void'(sb.pop_front());
            end
        end
        if (acc) begin
            a = l[4*int'(gid) +: 4];
            b = r[4*int'(gid) +: 4];
            ent.id   = gid;
            ent.data = {4'b0000, a} * {4'b0000, b};
            sb.push_back(ent);
            m_last = gid;
        end
        if (m_s1v && s2a) m_s2v = 1'b1;
        else if (rr)      m_s2v = 1'b0;
        if (acc)          m_s1v = 1'b1;
        else if (s1a)     m_s1v = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b0;
        io_req_valid  = 4'h0;
        io_req_lhs    = 16'h0000;
        io_req_rhs    = 16'h0000;
        io_resp_ready = 1'b0;

        // all valid, req i: lhs=i+12, rhs=15 -> B4, C3, D2, E1; grants 0,1,2,3,0,1
        add(4'b1111, 16'hFEDC, 16'hFFFF, 1'b1, 4'b0001);
        add(4'b1111, 16'hFEDC, 16'hFFFF, 1'b1, 4'b0010);
        add(4'b1111, 16'hFEDC, 16'hFFFF, 1'b1, 4'b0100);
        add(4'b1111, 16'hFEDC, 16'hFFFF, 1'b1, 4'b1000);
        add(4'b1111, 16'hFEDC, 16'hFFFF, 1'b1, 4'b0001);
        add(4'b1111, 16'hFEDC, 16'hFFFF, 1'b1, 4'b0010);
        for (int i = 0; i < 3; i++) add(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000);
        // single request 3*5 = 0x0F (last=1 -> search 2,3,0)
        add(4'b0001, 16'h0003, 16'h0005, 1'b1, 4'b0001);
        for (int i = 0; i < 3; i++) add(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000);
        // boundary values: req2 15*15 = 0xE1, req3 0*9 = 0x00
        add(4'b0100, 16'h0F00, 16'h0F00, 1'b1, 4'b0100);
        add(4'b1000, 16'h0000, 16'h9000, 1'b1, 4'b1000);
        for (int i = 0; i < 3; i++) add(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000);
        // wrap and skip: only req1 and req3, last=3
        add(4'b1010, 16'h5020, 16'h7030, 1'b1, 4'b0010);
        add(4'b1010, 16'h5020, 16'h7030, 1'b1, 4'b1000);
        add(4'b1010, 16'h5020, 16'h7030, 1'b1, 4'b0010);
        for (int i = 0; i < 3; i++) add(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000);
        // back-pressure: two accepts then stall, then drain in order
        add(4'b0010, 16'h0020, 16'h0030, 1'b0, 4'b0010);
        add(4'b0010, 16'h0040, 16'h0030, 1'b0, 4'b0010);
        add(4'b0010, 16'h0050, 16'h0030, 1'b0, 4'b0000);
        add(4'b0010, 16'h0050, 16'h0030, 1'b0, 4'b0000);
        add(4'b0010, 16'h0050, 16'h0030, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) add(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000);

        repeat (2) @(negedge clk);
        #1;
        check("reset_resp_valid", 32'(io_resp_valid), 32'd0);
        check("reset_busy", 32'(io_busy), 32'd0);
        check("reset_resp_data", 32'(io_resp_data), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) step(tbl[i].valid, tbl[i].lhs, tbl[i].rhs, tbl[i].rr, tbl[i].exp_rdy);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // reset mid-flight: fill S1 and S2, then assert reset
        step(4'b0001, 16'h0007, 16'h0007, 1'b0, 4'b0001);
        step(4'b0001, 16'h0006, 16'h0007, 1'b0, 4'b0001);
        reset = 1'b0;
        #1;
        check("midrst_resp_valid", 32'(io_resp_valid), 32'd0);
        check("midrst_busy", 32'(io_busy), 32'd0);
        check("midrst_req_ready", 32'(io_req_ready), 32'd0);
        sb.delete();
        m_s1v  = 1'b0;
        m_s2v  = 1'b0;
        m_last = 2'd3;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(4'b0011, 16'h0012, 16'h0033, 1'b1, 4'b0001);
        for (int i = 0; i < 3; i++) step(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000);
        check("sb_final", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
